// File: rtl/spio_hss_multiplexer_reg_bank_if.sv
// spio_hss_multiplexer_reg_bank_if: word-addressed configuration bus of the register bank
`ifndef CRDT_BITS
`define CRDT_BITS 6
`endif
`ifndef NUM_CHANS
`define NUM_CHANS 8
`endif
interface spio_hss_multiplexer_reg_bank_if #(
    parameter int ADDR_BITS = 5,
    parameter int CNT_BITS  = 32
);
    logic [ADDR_BITS-1:0] cfg_addr;
    logic                 cfg_wr;
    logic [CNT_BITS-1:0]  cfg_wdata;
    logic                 cfg_rd;
    logic [CNT_BITS-1:0]  cfg_rdata;
    logic                 cfg_rvld;
    modport master (output cfg_addr, cfg_wr, cfg_wdata, cfg_rd, input cfg_rdata, cfg_rvld);
    modport slave (input cfg_addr, cfg_wr, cfg_wdata, cfg_rd, output cfg_rdata, cfg_rvld);
endinterface

// File: rtl/spio_hss_multiplexer_reg_bank.sv
// spio_hss_multiplexer_reg_bank: spiNNlink event counters, status and control registers.
// Optional error interrupt and IRQ_MASK register enabled by SPIO_HSS_MUX_REG_IRQ_EN.
`ifndef CRDT_BITS
`define CRDT_BITS 6
`endif
`ifndef NUM_CHANS
`define NUM_CHANS 8
`endif
module spio_hss_multiplexer_reg_bank #(
    parameter int          CNT_BITS  = 32,
    parameter int          ADDR_BITS = 5,
    parameter logic [31:0] VERSION   = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_sfrm,
    input  logic                  reg_looc,
    input  logic                  reg_tfrm,
    input  logic                  reg_dfrm,
    input  logic                  reg_crce,
    input  logic                  reg_frme,
    input  logic                  reg_rnak,
    input  logic                  reg_rack,
    input  logic                  reg_rooc,
    input  logic                  reg_rfrm,
    input  logic                  reg_busy,
    input  logic                  reg_lnak,
    input  logic                  reg_lack,
    input  logic [`CRDT_BITS-1:0] reg_crdt,
    input  logic [`NUM_CHANS-1:0] reg_empt,
    input  logic [`NUM_CHANS-1:0] reg_full,
    input  logic [`NUM_CHANS-1:0] reg_cfcr,
    input  logic [`NUM_CHANS-1:0] reg_cfcl,
    output logic                  reg_stop,
    spio_hss_multiplexer_reg_bank_if.slave cfg,
    output logic                  irq
);
    localparam int NCNT = 13;
    logic [NCNT-1:0]     ev;
    logic [CNT_BITS-1:0] cnt [NCNT];
    logic [CNT_BITS-1:0] rmux;
    logic [2:0]          mask;
    logic                wr_ctrl;
    logic                clr_all;
    logic                unused_ok;
    // bit i of ev feeds the counter at word address i+2
    assign ev = {reg_lack, reg_lnak, reg_busy, reg_rfrm, reg_rooc, reg_rack, reg_rnak,
                 reg_frme, reg_crce, reg_dfrm, reg_tfrm, reg_looc, reg_sfrm};
    assign wr_ctrl   = cfg.cfg_wr && cfg.cfg_addr == ADDR_BITS'(1);
    assign clr_all   = wr_ctrl && cfg.cfg_wdata[1];
    assign unused_ok = &{1'b0, cfg.cfg_wdata};
    // any clear beats a coincident event
    always_ff @(posedge clk)
        for (int i = 0; i < NCNT; i++)
            if (rst || clr_all || (cfg.cfg_wr && cfg.cfg_addr == ADDR_BITS'(i + 2))) cnt[i] <= '0;
            else if (ev[i] && !(&cnt[i])) cnt[i] <= cnt[i] + CNT_BITS'(1);
    always_comb begin
        rmux = '0;
        for (int i = 0; i < NCNT; i++)
            if (cfg.cfg_addr == ADDR_BITS'(i + 2)) rmux = cnt[i];
        case (cfg.cfg_addr)
            ADDR_BITS'(0):  rmux = CNT_BITS'(VERSION);
            ADDR_BITS'(1):  rmux = CNT_BITS'(reg_stop);
            ADDR_BITS'(15): rmux = CNT_BITS'(reg_crdt);
            ADDR_BITS'(16): rmux = CNT_BITS'(reg_empt);
            ADDR_BITS'(17): rmux = CNT_BITS'(reg_full);
            ADDR_BITS'(18): rmux = CNT_BITS'(reg_cfcr);
            ADDR_BITS'(19): rmux = CNT_BITS'(reg_cfcl);
            ADDR_BITS'(20): rmux = CNT_BITS'(mask);
            default: ;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            reg_stop      <= 1'b0;
            cfg.cfg_rdata <= '0;
            cfg.cfg_rvld  <= 1'b0;
        end else begin
            if (wr_ctrl) reg_stop <= cfg.cfg_wdata[0];
            if (cfg.cfg_rd) cfg.cfg_rdata <= rmux;
            cfg.cfg_rvld <= cfg.cfg_rd;
        end
`ifdef SPIO_HSS_MUX_REG_IRQ_EN
    always_ff @(posedge clk)
        if (rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (cfg.cfg_wr && cfg.cfg_addr == ADDR_BITS'(20)) mask <= cfg.cfg_wdata[2:0];
            irq <= |(mask & {|cnt[6], |cnt[5], |cnt[4]});
        end
`else
    assign mask = '0;
    assign irq  = 1'b0;
`endif
endmodule

// File: tb/tb_spio_hss_multiplexer_reg_bank.sv
// tb_spio_hss_multiplexer_reg_bank: directed table-driven bench for the register bank
`ifndef CRDT_BITS
`define CRDT_BITS 6
`endif
`ifndef NUM_CHANS
`define NUM_CHANS 8
`endif
module tb_spio_hss_multiplexer_reg_bank;
`ifdef SPIO_HSS_MUX_REG_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [12:0] ev;
    logic [`CRDT_BITS-1:0] crdt;
    logic [`NUM_CHANS-1:0] empt, full, cfcr, cfcl;
    logic stop, irq, stop8, irq8;
    int checks = 0;
    int errors = 0;
    vec_t tbl [23];

    always #5 clk = ~clk;

    spio_hss_multiplexer_reg_bank_if #(.ADDR_BITS(5), .CNT_BITS(32)) cfg ();
    spio_hss_multiplexer_reg_bank_if #(.ADDR_BITS(5), .CNT_BITS(8))  cfg8 ();
    assign cfg8.cfg_addr  = cfg.cfg_addr;
    assign cfg8.cfg_wr    = cfg.cfg_wr;
    assign cfg8.cfg_wdata = cfg.cfg_wdata[7:0];
    assign cfg8.cfg_rd    = cfg.cfg_rd;

    spio_hss_multiplexer_reg_bank #(.CNT_BITS(32), .ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .reg_sfrm(ev[0]), .reg_looc(ev[1]), .reg_tfrm(ev[2]), .reg_dfrm(ev[3]),
        .reg_crce(ev[4]), .reg_frme(ev[5]), .reg_rnak(ev[6]), .reg_rack(ev[7]),
        .reg_rooc(ev[8]), .reg_rfrm(ev[9]), .reg_busy(ev[10]), .reg_lnak(ev[11]),
        .reg_lack(ev[12]), .reg_crdt(crdt), .reg_empt(empt), .reg_full(full),
        .reg_cfcr(cfcr), .reg_cfcl(cfcl), .reg_stop(stop), .cfg(cfg), .irq(irq)
    );

    spio_hss_multiplexer_reg_bank #(.CNT_BITS(8), .ADDR_BITS(5)) dut8 (
        .clk(clk), .rst(rst),
        .reg_sfrm(ev[0]), .reg_looc(ev[1]), .reg_tfrm(ev[2]), .reg_dfrm(ev[3]),
        .reg_crce(ev[4]), .reg_frme(ev[5]), .reg_rnak(ev[6]), .reg_rack(ev[7]),
        .reg_rooc(ev[8]), .reg_rfrm(ev[9]), .reg_busy(ev[10]), .reg_lnak(ev[11]),
        .reg_lack(ev[12]), .reg_crdt(crdt), .reg_empt(empt), .reg_full(full),
        .reg_cfcr(cfcr), .reg_cfcl(cfcl), .reg_stop(stop8), .cfg(cfg8), .irq(irq8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        cfg.cfg_addr = a;
        cfg.cfg_rd   = 1'b1;
        tick();
        cfg.cfg_rd = 1'b0;
        check({name, " rvld"}, 32'(cfg.cfg_rvld), 32'd1);
        check(name, cfg.cfg_rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg.cfg_addr  = a;
        cfg.cfg_wdata = d;
        cfg.cfg_wr    = 1'b1;
        tick();
        cfg.cfg_wr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 22; i++) tbl[i] = '{addr: 5'(i), exp: 32'h0};
        tbl[22] = '{addr: 5'h1F, exp: 32'h0};
        tbl[0].exp  = 32'h0001_0000;
        tbl[4].exp  = 32'd5;
        tbl[6].exp  = 32'd3;
        tbl[15].exp = 32'd5;
        tbl[16].exp = 32'hA5;
        tbl[17].exp = 32'h3C;
        tbl[18].exp = 32'h0F;
        tbl[19].exp = 32'hF0;
        rst = 1'b1;
        ev = '0;
        crdt = '0;
        {empt, full, cfcr, cfcl} = '0;
        cfg.cfg_addr = '0;
        cfg.cfg_wr = 1'b0;
        cfg.cfg_wdata = '0;
        cfg.cfg_rd = 1'b0;
        repeat (3) tick();
        check("reset rvld", 32'(cfg.cfg_rvld), 32'd0);
        check("reset rdata", cfg.cfg_rdata, 32'd0);
        check("reset stop", 32'(stop), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("version", 5'h00, 32'h0001_0000);
        rd_chk("ctrl reset", 5'h01, 32'd0);
        tick();
        check("rvld one cycle", 32'(cfg.cfg_rvld), 32'd0);
        check("rdata hold", cfg.cfg_rdata, 32'd0);
        // event counting and status
        crdt = `CRDT_BITS'(5);
        empt = `NUM_CHANS'(8'hA5);
        full = `NUM_CHANS'(8'h3C);
        cfcr = `NUM_CHANS'(8'h0F);
        cfcl = `NUM_CHANS'(8'hF0);
        for (int i = 0; i < 5; i++) begin
            ev[2] = 1'b1;
            ev[4] = (i % 2 == 0);
            tick();
        end
        ev = '0;
        for (int i = 0; i < 23; i++) rd_chk($sformatf("reg 0x%0h", tbl[i].addr), tbl[i].addr, tbl[i].exp);
        // back-to-back reads
        cfg.cfg_addr = 5'h00;
        cfg.cfg_rd = 1'b1;
        tick();
        check("b2b first rvld", 32'(cfg.cfg_rvld), 32'd1);
        check("b2b first data", cfg.cfg_rdata, 32'h0001_0000);
        cfg.cfg_addr = 5'h04;
        tick();
        cfg.cfg_rd = 1'b0;
        check("b2b second rvld", 32'(cfg.cfg_rvld), 32'd1);
        check("b2b second data", cfg.cfg_rdata, 32'd5);
        tick();
        check("b2b idle rvld", 32'(cfg.cfg_rvld), 32'd0);
        check("b2b idle hold", cfg.cfg_rdata, 32'd5);
        // saturation on the 8-bit instance
        ev[0] = 1'b1;
        repeat (300) tick();
        ev[0] = 1'b0;
        rd_chk("sfrm 32b", 5'h02, 32'd300);
        check("sfrm 8b saturated", 32'(cfg8.cfg_rdata), 32'hFF);
        // read/increment and read/write collisions
        ev[2] = 1'b1;
        rd_chk("tfrm pre-increment", 5'h04, 32'd5);
        cfg.cfg_addr = 5'h04;
        cfg.cfg_wr = 1'b1;
        cfg.cfg_rd = 1'b1;
        tick();
        {cfg.cfg_wr, cfg.cfg_rd} = 2'b00;
        ev[2] = 1'b0;
        check("rd+wr rvld", 32'(cfg.cfg_rvld), 32'd1);
        check("rd+wr pre-clear", cfg.cfg_rdata, 32'd6);
        rd_chk("tfrm clear wins", 5'h04, 32'd0);
        // CLR coincident with an event
        ev[3] = 1'b1;
        tick();
        ev[3] = 1'b0;
        rd_chk("dfrm one", 5'h05, 32'd1);
        ev[3] = 1'b1;
        wr(5'h01, 32'd2);
        ev[3] = 1'b0;
        for (int a = 2; a <= 14; a++) rd_chk($sformatf("clr cnt 0x%0h", a), 5'(a), 32'd0);
        rd_chk("ctrl clr self-clear", 5'h01, 32'd0);
        check("stop after clr", 32'(stop), 32'd0);
        // STOP control and read-only write
        wr(5'h01, 32'd1);
        check("stop set", 32'(stop), 32'd1);
        rd_chk("ctrl stop", 5'h01, 32'd1);
        wr(5'h01, 32'd0);
        check("stop cleared", 32'(stop), 32'd0);
        wr(5'h00, 32'hDEAD_BEEF);
        rd_chk("version read-only", 5'h00, 32'h0001_0000);
        // interrupt
        wr(5'h14, 32'd1);
        rd_chk("irq_mask", 5'h14, IRQ_EN ? 32'd1 : 32'd0);
        ev[4] = 1'b1;
        tick();
        ev[4] = 1'b0;
        check("irq not yet", 32'(irq), 32'd0);
        tick();
        check("irq asserted", 32'(irq), IRQ_EN ? 32'd1 : 32'd0);
        wr(5'h06, 32'd0);
        check("irq held at clear", 32'(irq), IRQ_EN ? 32'd1 : 32'd0);
        tick();
        check("irq after counter clear", 32'(irq), 32'd0);
        ev[4] = 1'b1;
        tick();
        ev[4] = 1'b0;
        tick();
        check("irq reasserted", 32'(irq), IRQ_EN ? 32'd1 : 32'd0);
        wr(5'h14, 32'd0);
        tick();
        check("irq after mask clear", 32'(irq), 32'd0);
        // reset during a read
        cfg.cfg_addr = 5'h00;
        cfg.cfg_rd = 1'b1;
        rst = 1'b1;
        tick();
        cfg.cfg_rd = 1'b0;
        check("rst mid-read rvld", 32'(cfg.cfg_rvld), 32'd0);
        check("rst mid-read rdata", cfg.cfg_rdata, 32'd0);
        rst = 1'b0;
        tick();
        check("read dropped", 32'(cfg.cfg_rvld), 32'd0);
        rd_chk("crce after rst", 5'h06, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spio_hss_multiplexer_reg_bank.md
Name: spio_hss_multiplexer_reg_bank

Overview:
Register bank sitting at the far end of the spiNNlink register interface.
- Consumes the single-cycle event pulses and the status vectors that the spiNNlink core drives (frame assembler, transmitter, disassembler, dispatcher).
- Counts events in per-event saturating counters and exposes counters, status and control over a simple word-addressed read/write bus.
- Drives reg_stop back into the frame transmitter.

Parameters:
CNT_BITS, 32, width of every event counter and of the bus data path.
ADDR_BITS, 5, word-address width of the configuration bus.
VERSION, 32'h0001_0000, constant returned at address 0x00.

Ports:
clk  in  1  clock
rst  in  1  reset
reg_sfrm, reg_looc, reg_tfrm, reg_dfrm, reg_crce, reg_frme, reg_rnak, reg_rack, reg_rooc, reg_rfrm, reg_busy, reg_lnak, reg_lack  in  1 each  event pulses, one event per asserted cycle
reg_crdt  in  `CRDT_BITS  current credit
reg_empt, reg_full  in  `NUM_CHANS each  assembler channel queue status
reg_cfcr, reg_cfcl  in  `NUM_CHANS each  remote/local channel flow control
reg_stop  out  1  stop transmitter (CTRL.STOP)
cfg_addr  in  ADDR_BITS  word address
cfg_wr  in  1  write strobe
cfg_wdata  in  CNT_BITS  write data
cfg_rd  in  1  read strobe
cfg_rdata  out  CNT_BITS  read data
cfg_rvld  out  1  read data valid
irq  out  1  error interrupt

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all counters 0; CTRL.STOP 0 (so reg_stop 0); IRQ_MASK 0.
  - cfg_rdata 0, cfg_rvld 0, irq 0.
- Register map (word address, read-only unless stated; unmapped addresses read 0, writes to them ignored):
  - 0x00 VERSION.
  - 0x01 CTRL (rw): bit0 STOP; bit1 CLR, write-1 self-clearing, always reads 0.
  - 0x02..0x0E counters, in order: SFRM, LOOC, TFRM, DFRM, CRCE, FRME, RNAK, RACK, ROOC, RFRM, BUSY, LNAK, LACK.
  - 0x0F CRDT, zero-extended.
  - 0x10 EMPT, 0x11 FULL, 0x12 CFCR, 0x13 CFCL, each zero-extended.
  - 0x14 IRQ_MASK (rw): bit0 CRCE, bit1 FRME, bit2 RNAK.
- Counters:
  - +1 on each cycle the matching event input is high.
  - Saturate at all-ones; never wrap.
  - Any write to a counter address clears that counter only; wdata is ignored.
  - CLR=1 clears all counters on the following edge.
  - Clear (CLR or per-counter write) coincident with an event: clear wins, result 0, the event is lost.
- Read handshake:
  - cfg_rd high in cycle N → cfg_rdata valid and cfg_rvld high for exactly one cycle in N+1.
  - cfg_rvld is low in every other cycle. cfg_rdata holds its last value while cfg_rvld is low.
  - Back-to-back reads are allowed, one per cycle, full throughput.
  - Status registers are sampled in cycle N.
- Read/modify collisions:
  - Read coincident with an increment, or with a write to the same address: returns the pre-update value.
  - cfg_rd and cfg_wr in the same cycle are both honoured.
- reg_stop: registered copy of CTRL.STOP; changes on the edge after the write.
- rst mid-read: cfg_rvld is 0 in the cycle after reset, and the pending read is dropped.

Optional Feature:
Macro: SPIO_HSS_MUX_REG_IRQ_EN.
- Defined:
  - irq is registered and asserts one cycle after any counter whose IRQ_MASK bit is set becomes non-zero: CRCE (bit0), FRME (bit1), RNAK (bit2).
  - irq stays high until that counter is cleared or the mask bit is cleared.
  - IRQ_MASK is read/write.
- Not defined:
  - irq tied to 0.
  - IRQ_MASK reads 0 and writes to it are ignored.
  - No mask or interrupt logic is synthesised.

Test Plan:
1. Reset, then read 0x00 and 0x01 → cfg_rvld high on the cycle after each cfg_rd. Data 32'h0001_0000 and 0. reg_stop=0.
2. Pulse reg_tfrm for 5 cycles and reg_crce for 3 non-consecutive cycles → TFRM (0x04) reads 5, CRCE (0x06) reads 3, all other counters read 0.
3. With CNT_BITS=8, hold reg_sfrm high for 300 cycles → SFRM reads 8'hFF.
4. Write CTRL=2 while reg_dfrm is high in the same cycle → every counter reads 0, including DFRM. A subsequent CTRL read returns 0.
5. Write CTRL=1 → reg_stop=1 from the next edge. Write CTRL=0 → reg_stop returns to 0. Drive reg_crdt=5 and reg_empt=8'hA5 → 0x0F reads 5, 0x10 reads 32'hA5.
6. With SPIO_HSS_MUX_REG_IRQ_EN defined: write IRQ_MASK=1, then pulse reg_crce once → irq=1 one cycle after CRCE becomes 1. Write to 0x06 → irq=0. Without the macro, irq stays 0 throughout.
